dice_roll_ctrl: RTL and testbench
=================================

# dice_roll_ctrl

Sequencing controller for the dice roller's LFSR. It accepts a roll request (die type plus number of dice) and steps the external 8-bit LFSR once per draw. Each draw is reduced to a uniform face value in 1..N by rejection sampling with a bounded fold fallback. The faces are accumulated, and the total is presented on a valid/ready result port that feeds the output pin mux.

## Interface
Parameters:
- MAX_RETRY, 3: rejected draws allowed per die before fold fallback; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  roll request present.
- req_ready  out  1  controller idle and able to accept a request.
- req_die  in  3  die type: 0=d4, 1=d6, 2=d8, 3=d10, 4=d12, 5=d20, 6=d100, 7=d2.
- req_count  in  3  number of dice; 1..7 literal, 0 means 8.
- lfsr_step  out  1  one-cycle pulse that advances the external LFSR at the same clock edge.
- lfsr_q  in  8  current LFSR state; stable except after a lfsr_step edge.
- res_valid  out  1  result available; held until accepted.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  10  sum of all faces (max 800).
- res_last  out  7  face of the last die rolled (1..100).
- res_folds  out  4  count of fold fallbacks in this roll; saturates at 15.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, STEP, SAMPLE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch die and count, clear sum, retry counter and folds, then go to STEP.
- STEP:
  - lfsr_step=1 for exactly this cycle, then go to SAMPLE.
- SAMPLE:
  - Compute m = lfsr_q & mask(N).
  - Mask widths: d2 1 bit, d4 2, d6 3, d8 3, d10 4, d12 4, d20 5, d100 7.
  - m < N (accept): face = m+1, sum += face, res_last = face, retry cleared, remaining decremented. If remaining reaches 0, go to DONE; otherwise go to STEP.
  - m ≥ N and retry < MAX_RETRY: retry++, go to STEP with no accumulation.
  - m ≥ N and retry == MAX_RETRY (fold): face = m−N+1. This is always in 1..N because m < 2N. Accumulate as for an accept, and increment res_folds.
- DONE:
  - res_valid=1 with res_sum, res_last and res_folds stable.
  - On res_ready, go to IDLE.
- Arithmetic: sum is 10 bits unsigned and cannot overflow (8×100 = 800 < 1024).
- Requests are ignored while busy. req_ready=0 prevents acceptance.
- Outputs res_sum, res_last and res_folds hold their values after DONE until the next request is accepted.

## Timing
- Reset (async, immediate): state=IDLE, req_ready=1, busy=0, lfsr_step=0, res_valid=0, res_sum=0, res_last=0, res_folds=0, retry=0. Roll-flag outputs reset to 0.
- Request accepted at edge E0. lfsr_step is high during cycle E0→E1, and lfsr_q is sampled in cycle E1→E2.
- Latency with no rejections: res_valid rises 2n cycles after acceptance, where n is the number of dice. Each rejection adds 2 cycles.
- Worst case: 2·8·(MAX_RETRY+1) cycles.
- res_valid with res_ready already high completes in one cycle. req_ready returns the following cycle, so there is no same-cycle result/request overlap.
- rst asserted mid-roll aborts the roll immediately. No lfsr_step is issued after the reset edge, and the partial sum is discarded.

## Configuration
- DICE_CRIT_EN defined:
  - Adds outputs res_crit (1 bit) and res_fumble (1 bit), valid with res_valid.
  - res_crit=1 if any d20 face equals 20.
  - res_fumble=1 if any d20 face equals 1.
  - Both flags are cleared on request acceptance and forced 0 for other die types.
- DICE_CRIT_EN undefined: the ports and logic are absent. Everything else is unchanged.

## Test plan
- d6, count 1, LFSR model yields 0x05 → face 6; res_sum=6, res_last=6, res_folds=0; res_valid 2 cycles after acceptance.
- d6, count 1, sequence 0x07, 0x02 → first draw rejected, face 3; res_sum=3; exactly 2 lfsr_step pulses; latency 4 cycles.
- d20, MAX_RETRY=2, sequence 0x1F, 0x1F, 0x1F → fold, face 12; res_folds=1; 3 lfsr_step pulses.
- d100, count 0 (8 dice), every draw 0x63 → res_sum=800, res_last=100; latency 16 cycles. With DICE_CRIT_EN: crit=0, fumble=0.
- Hold res_ready=0 for 5 cycles in DONE while pulsing req_valid → res_valid and outputs stable, request not accepted; res_ready=1 → IDLE next cycle.
- Assert rst during the third SAMPLE of a 4-die roll → all outputs at reset values immediately, no further lfsr_step. A new d4 request then completes normally.

Source files
------------

// File: rtl/dice_roll_ctrl.sv
// Dice roller sequencer: steps an external 8-bit LFSR, reduces each draw to a face by
// rejection sampling with a fold fallback, and sums the faces. Optional feature: DICE_CRIT_EN.
module dice_roll_ctrl #(
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_die,
    input  logic [2:0] req_count,
    output logic       lfsr_step,
    input  logic [7:0] lfsr_q,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [9:0] res_sum,
    output logic [6:0] res_last,
    output logic [3:0] res_folds,
`ifdef DICE_CRIT_EN
    output logic       res_crit,
    output logic       res_fumble,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, STEP, SAMPLE, DONE} state_t;

    localparam logic [3:0] MaxRetry = 4'(MAX_RETRY);

    state_t     state_q;
    logic [2:0] die_q;
    logic [3:0] left_q;
    logic [3:0] retry_q;
    logic [9:0] sum_q;
    logic [6:0] last_q;
    logic [3:0] folds_q;
`ifdef DICE_CRIT_EN
    logic       crit_q, fumble_q;
`endif

    logic [6:0] n_d, mask_d;
    logic [7:0] m_d, face_d;
    logic       accept_d, fold_d;

    always_comb begin
        n_d    = 7'd4;
        mask_d = 7'h03;
        case (die_q)
            3'd0: begin n_d = 7'd4;   mask_d = 7'h03; end
            3'd1: begin n_d = 7'd6;   mask_d = 7'h07; end
            3'd2: begin n_d = 7'd8;   mask_d = 7'h07; end
            3'd3: begin n_d = 7'd10;  mask_d = 7'h0F; end
            3'd4: begin n_d = 7'd12;  mask_d = 7'h0F; end
            3'd5: begin n_d = 7'd20;  mask_d = 7'h1F; end
            3'd6: begin n_d = 7'd100; mask_d = 7'h7F; end
            default: begin n_d = 7'd2; mask_d = 7'h01; end
        endcase
        m_d      = lfsr_q & {1'b0, mask_d};
        accept_d = m_d < {1'b0, n_d};
        fold_d   = !accept_d && (retry_q == MaxRetry);
        // mask width guarantees m < 2N, so the folded face always lands in 1..N
        face_d   = accept_d ? (m_d + 8'd1) : (m_d - {1'b0, n_d} + 8'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            die_q    <= '0;
            left_q   <= '0;
            retry_q  <= '0;
            sum_q    <= '0;
            last_q   <= '0;
            folds_q  <= '0;
`ifdef DICE_CRIT_EN
            crit_q   <= 1'b0;
            fumble_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    die_q    <= req_die;
                    left_q   <= (req_count == 3'd0) ? 4'd8 : {1'b0, req_count};
                    retry_q  <= '0;
                    sum_q    <= '0;
                    folds_q  <= '0;
`ifdef DICE_CRIT_EN
                    crit_q   <= 1'b0;
                    fumble_q <= 1'b0;
`endif
                    state_q  <= STEP;
                end
                STEP: state_q <= SAMPLE;
                SAMPLE: begin
                    if (accept_d || fold_d) begin
                        sum_q   <= sum_q + {2'b00, face_d};
                        last_q  <= face_d[6:0];
                        retry_q <= '0;
                        left_q  <= left_q - 4'd1;
                        if (fold_d && folds_q != 4'hF) folds_q <= folds_q + 4'd1;
`ifdef DICE_CRIT_EN
                        if (die_q == 3'd5 && face_d == 8'd20) crit_q   <= 1'b1;
                        if (die_q == 3'd5 && face_d == 8'd1)  fumble_q <= 1'b1;
`endif
                        state_q <= (left_q == 4'd1) ? DONE : STEP;
                    end else begin
                        retry_q <= retry_q + 4'd1;
                        state_q <= STEP;
                    end
                end
                DONE: if (res_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode straight from the state register, so reset clears them at once.
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign lfsr_step = (state_q == STEP);
    assign res_valid = (state_q == DONE);
    assign res_sum   = sum_q;
    assign res_last  = last_q;
    assign res_folds = folds_q;
`ifdef DICE_CRIT_EN
    assign res_crit   = crit_q;
    assign res_fumble = fumble_q;
`endif

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Self-checking bench for dice_roll_ctrl: a queue-driven LFSR stand-in plus a draw-log reference model.
module tb_dice_roll_ctrl;

    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_die = '0;
    logic [2:0] req_count = '0;
    logic       lfsr_step;
    logic [7:0] lfsr_val = 8'h00;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [9:0] res_sum;
    logic [6:0] res_last;
    logic [3:0] res_folds;
    logic       busy;
`ifdef DICE_CRIT_EN
    logic       res_crit, res_fumble;
`endif

    int checks = 0;
    int failures = 0;

    byte unsigned feed[$];
    byte unsigned log_q[$];
    byte unsigned nv;

    dice_roll_ctrl #(.MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_die(req_die), .req_count(req_count),
        .lfsr_step(lfsr_step), .lfsr_q(lfsr_val),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_last(res_last), .res_folds(res_folds),
`ifdef DICE_CRIT_EN
        .res_crit(res_crit), .res_fumble(res_fumble),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External LFSR stand-in: scripted values first, random once the script runs dry.
    always @(posedge clk) begin
        if (lfsr_step) begin
            nv = (feed.size() != 0) ? feed.pop_front() : 8'($urandom_range(0, 255));
            lfsr_val <= nv;
            log_q.push_back(nv);
        end
    end

    function automatic int die_n(input logic [2:0] d);
        case (d)
            3'd0: return 4;   3'd1: return 6;  3'd2: return 8;   3'd3: return 10;
            3'd4: return 12;  3'd5: return 20; 3'd6: return 100; default: return 2;
        endcase
    endfunction

    function automatic int die_bits(input logic [2:0] d);
        case (d)
            3'd0: return 2; 3'd1: return 3; 3'd2: return 3; 3'd3: return 4;
            3'd4: return 4; 3'd5: return 5; 3'd6: return 7; default: return 1;
        endcase
    endfunction

    // Replays the logged draws through the roll rules; used = draws consumed, -1 if log ran short.
    task automatic model(input logic [2:0] die, input logic [2:0] cnt, output int sum,
                         output int last, output int folds, output int used,
                         output bit crit, output bit fumble);
        int n, modv, dice, r, m, face;
        bit done;
        n = die_n(die);
        modv = 1 << die_bits(die);
        dice = (cnt == 0) ? 8 : int'(cnt);
        sum = 0; last = 0; folds = 0; used = 0; crit = 0; fumble = 0;
        for (int d = 0; d < dice; d++) begin
            r = 0; done = 0; face = 0;
            while (!done) begin
                if (used >= log_q.size()) begin used = -1; return; end
                m = int'(log_q[used]) % modv;
                used++;
                if (m < n) begin face = m + 1; done = 1; end
                else if (r < MR) r++;
                else begin face = m - n + 1; folds++; done = 1; end
            end
            sum += face;
            last = face;
            if (n == 20 && face == 20) crit = 1;
            if (n == 20 && face == 1) fumble = 1;
        end
        if (folds > 15) folds = 15;
    endtask

    task automatic do_roll(input logic [2:0] die, input logic [2:0] cnt, input bit release_it,
                           output int lat);
        log_q.delete();
        req_die = die; req_count = cnt; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!res_valid) lat = -1;
        if (release_it) begin
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({req_ready, busy, lfsr_step, res_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 1000", {req_ready, busy, lfsr_step, res_valid});
        end
        checks++;
        if (res_sum !== 10'd0 || res_last !== 7'd0 || res_folds !== 4'd0) begin
            failures++;
            $display("FAIL reset_res: got sum=%0d last=%0d folds=%0d expected 0/0/0", res_sum, res_last, res_folds);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_accept;
        int lat;
        feed = {8'h05};
        do_roll(3'd1, 3'd1, 1, lat);
        checks++;
        if (res_sum !== 10'd6 || res_last !== 7'd6 || res_folds !== 4'd0) begin
            failures++;
            $display("FAIL accept_d6: got sum=%0d last=%0d folds=%0d expected 6/6/0", res_sum, res_last, res_folds);
        end
        checks++;
        if (lat != 2) begin failures++; $display("FAIL accept_lat: got %0d expected 2", lat); end
    endtask

    task automatic test_reject;
        int lat;
        feed = {8'h07, 8'h02};
        do_roll(3'd1, 3'd1, 1, lat);
        checks++;
        if (res_sum !== 10'd3 || res_last !== 7'd3) begin
            failures++;
            $display("FAIL reject_face: got sum=%0d last=%0d expected 3/3", res_sum, res_last);
        end
        checks++;
        if (log_q.size() != 2 || lat != 4) begin
            failures++;
            $display("FAIL reject_steps: got steps=%0d lat=%0d expected 2/4", log_q.size(), lat);
        end
    endtask

    task automatic test_fold;
        int lat;
        feed = {8'h1F, 8'h1F, 8'h1F};
        do_roll(3'd5, 3'd1, 1, lat);
        checks++;
        if (res_last !== 7'd12 || res_sum !== 10'd12 || res_folds !== 4'd1) begin
            failures++;
            $display("FAIL fold_d20: got last=%0d sum=%0d folds=%0d expected 12/12/1", res_last, res_sum, res_folds);
        end
        checks++;
        if (log_q.size() != 3 || lat != 6) begin
            failures++;
            $display("FAIL fold_steps: got steps=%0d lat=%0d expected 3/6", log_q.size(), lat);
        end
    endtask

    task automatic test_max_sum;
        int lat;
        feed.delete();
        repeat (8) feed.push_back(8'h63);
        do_roll(3'd6, 3'd0, 1, lat);
        checks++;
        if (res_sum !== 10'd800 || res_last !== 7'd100 || lat != 16) begin
            failures++;
            $display("FAIL d100x8: got sum=%0d last=%0d lat=%0d expected 800/100/16", res_sum, res_last, lat);
        end
`ifdef DICE_CRIT_EN
        checks++;
        if (res_crit !== 1'b0 || res_fumble !== 1'b0) begin
            failures++;
            $display("FAIL d100_flags: got %b%b expected 00", res_crit, res_fumble);
        end
`endif
    endtask

    task automatic test_random;
        int lat, s, l, f, u;
        bit c, fu;
        logic [2:0] die, cnt;
        feed.delete();
        for (int i = 0; i < 40; i++) begin
            die = 3'($urandom_range(0, 7));
            cnt = 3'($urandom_range(0, 7));
            if (i < 8) die = 3'd5;
            do_roll(die, cnt, 1, lat);
            model(die, cnt, s, l, f, u, c, fu);
            checks++;
            if (int'(res_sum) != s || int'(res_last) != l || int'(res_folds) != f) begin
                failures++;
                $display("FAIL rand_res[%0d]: got sum=%0d last=%0d folds=%0d expected %0d/%0d/%0d",
                         i, res_sum, res_last, res_folds, s, l, f);
            end
            checks++;
            if (u != log_q.size() || lat != 2 * log_q.size()) begin
                failures++;
                $display("FAIL rand_steps[%0d]: got used=%0d steps=%0d lat=%0d expected used=steps lat=2*steps",
                         i, u, log_q.size(), lat);
            end
`ifdef DICE_CRIT_EN
            checks++;
            if (res_crit !== c || res_fumble !== fu) begin
                failures++;
                $display("FAIL rand_flags[%0d]: got %b%b expected %b%b", i, res_crit, res_fumble, c, fu);
            end
`endif
        end
    endtask

    task automatic test_hold;
        int lat;
        feed = {8'h01};
        do_roll(3'd1, 3'd1, 0, lat);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_die = 3'd0; req_count = 3'd3;
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_sum !== 10'd2 || res_last !== 7'd2 ||
                lfsr_step !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d]: got valid=%b ready=%b sum=%0d last=%0d step=%b expected 1/0/2/2/0",
                         i, res_valid, req_ready, res_sum, res_last, lfsr_step);
            end
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1 || log_q.size() != 1 || res_sum !== 10'd2) begin
            failures++;
            $display("FAIL hold_release: got valid=%b ready=%b steps=%0d sum=%0d expected 0/1/1/2",
                     res_valid, req_ready, log_q.size(), res_sum);
        end
    endtask

    task automatic test_reset_mid;
        int lat, steps;
        feed = {8'h00, 8'h00, 8'h00, 8'h00};
        log_q.delete();
        req_die = 3'd1; req_count = 3'd4; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, busy, lfsr_step, res_valid} !== 4'b1000 || res_sum !== 10'd0 ||
            res_last !== 7'd0 || res_folds !== 4'd0) begin
            failures++;
            $display("FAIL midreset: got rdy/busy/step/vld=%b sum=%0d last=%0d folds=%0d expected 1000/0/0/0",
                     {req_ready, busy, lfsr_step, res_valid}, res_sum, res_last, res_folds);
        end
        steps = log_q.size();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (steps != 3 || log_q.size() != 3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_steps: got at_rst=%0d after=%0d busy=%b expected 3/3/0", steps, log_q.size(), busy);
        end
        feed.delete();
        feed = {8'h02};
        do_roll(3'd0, 3'd1, 1, lat);
        checks++;
        if (res_sum !== 10'd3 || res_last !== 7'd3 || lat != 2) begin
            failures++;
            $display("FAIL post_reset_d4: got sum=%0d last=%0d lat=%0d expected 3/3/2", res_sum, res_last, lat);
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_reject();
        test_fold();
        test_max_sum();
        test_hold();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
